// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and default word width for the bit serializer.
package serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serializer_holding_reg.sv
// serializer_holding_reg: single-entry word buffer (data register + full flag) with load/unload strobes.
module serializer_holding_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      full <= load ? 1'b1 : unload ? 1'b0 : full;
    end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial converter with a one-word holding buffer.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);
`ifdef SERIALIZER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t           state;
  logic [N-1:0]     sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;
  logic             last, accept, load_direct, buf_load, buf_unload;
  logic [WIDTH-1:0] src;
  logic [N-1:0]     frame;
  assign s_ready     = ~buf_full & ~reset;
  assign last        = (state == SHIFT) && (cnt == LAST);
  assign accept      = s_valid & s_ready;
  assign load_direct = accept & ((state == IDLE) | last);
  assign buf_load    = accept & (state == SHIFT) & ~last;
  assign buf_unload  = last & buf_full;
  assign src         = buf_unload ? buf_q : s_data;
`ifdef SERIALIZER_PARITY_EN
  assign frame = {src, ^src};
`else
  assign frame = src;
`endif
  serializer_holding_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .unload(buf_unload),
    .d     (s_data),
    .q     (buf_q),
    .full  (buf_full)
  );
  // the shift register is zeroed whenever idle, so serial_out needs no gating
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (buf_unload || load_direct) begin
      state <= SHIFT;
      sreg  <= frame;
      cnt   <= '0;
    end else if (last) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sreg <= {sreg[N-2:0], 1'b0};
      cnt  <= cnt + 1'b1;
    end
  assign serial_out   = sreg[N-1];
  assign serial_valid = (state == SHIFT);
  assign busy         = (state == SHIFT);
  assign word_done    = last;
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per parallel word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 s_data  input  WIDTH  parallel word to serialize.
REQ-005 s_valid  input  1  s_data holds a word offered for transfer.
REQ-006 s_ready  output  1  block can accept a word this cycle.
REQ-007 serial_out  output  1  serial bit stream, MSB first; feeds the downstream 1-bit sequence detector input.
REQ-008 serial_valid  output  1  serial_out carries a real bit this cycle.
REQ-009 word_done  output  1  one-cycle pulse coincident with the final bit of each word.
REQ-010 busy  output  1  high whenever state is SHIFT.

Function
REQ-011 A word SHALL be accepted on a posedge where s_valid && s_ready; s_data is captured at that edge.
REQ-012 The FSM SHALL have two states: IDLE (no word in flight) and SHIFT (word in flight).
REQ-013 IDLE -> SHIFT SHALL occur on acceptance; the accepted word loads the shift register directly, and its MSB appears on serial_out in the cycle immediately after the accepting edge (latency 1).
REQ-014 In SHIFT, one bit SHALL be presented per cycle, MSB to LSB, with serial_valid=1; a word occupies exactly WIDTH consecutive cycles.
REQ-015 A single-entry holding buffer SHALL accept one further word during SHIFT; s_ready = NOT buffer_full.
REQ-016 At the final-bit edge: if the buffer is full, its word SHALL load into the shift register and the buffer SHALL empty (no bubble); else, if s_valid is high, the offered word SHALL load directly (no bubble); else -> IDLE.
REQ-017 In IDLE, serial_out=0, serial_valid=0, word_done=0, busy=0.
REQ-018 s_data changes while not accepted SHALL have no effect; a word is never dropped or duplicated.
REQ-019 Bit counter width SHALL be $clog2(WIDTH+1); it wraps to 0 on each word boundary.

Reset
REQ-020 Asserting reset SHALL immediately force IDLE, clear the shift register, buffer and counter, and drive serial_out=0, serial_valid=0, word_done=0, busy=0.
REQ-021 Reset mid-word SHALL discard the in-flight and buffered words; no partial word resumes after release.
REQ-022 s_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.

Configuration
REQ-023 Macro SERIALIZER_PARITY_EN defined: after the WIDTH data bits, one extra bit equal to the even parity (XOR of all data bits) SHALL be emitted with serial_valid=1; word period = WIDTH+1 cycles; word_done coincides with the parity bit.
REQ-024 Macro SERIALIZER_PARITY_EN undefined: no parity bit; word period = WIDTH cycles; word_done coincides with the LSB.

Structure
REQ-025 Package serializer_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-026 The holding buffer SHALL be a sub-module, serializer_holding_reg (data register + full flag, load/unload strobes); everything else is inline.

Verification
REQ-027 Single word 8'hB6 accepted at cycle 0 -> serial_out 1,0,1,1,0,1,1,0 in cycles 1..8, serial_valid high for exactly those cycles, word_done in cycle 8, IDLE in cycle 9.
REQ-028 Back-to-back 8'hFF then 8'h00 with s_valid held high -> 16 consecutive valid bits (eight 1s, eight 0s), no gap; s_ready low once the buffer fills, high again after the buffer unloads.
REQ-029 Reset asserted at cycle 4 of word 8'hF0 with 8'h0F buffered -> outputs zero immediately; after release, no bits of either word appear; next word 8'h81 serializes cleanly.
REQ-030 Word 8'hFC feeding the downstream non-overlapping 111 detector -> bits 1,1,1,1,1,1,0,0 produce detector pulses on the 3rd and 6th bits only.
REQ-031 With SERIALIZER_PARITY_EN, word 8'hB6 (five 1s) -> 9 valid bits ending with parity bit 1, word_done in cycle 9; word 8'h03 -> parity bit 0.
REQ-032 s_valid pulsed for one cycle with s_data changing every cycle while busy and the buffer is full -> only words present on accepting edges appear, each exactly once, in order.
